// File: rtl/copcom_crc16.sv
// Bit-serial CRC-16 engine for the COPCOM coprocessor. A START edge loads the
// seed/data bytes, shifts 8 or 16 bits MSB-first through POLY, then holds the result.
module copcom_crc16 #(
  parameter logic [15:0] POLY    = 16'h1021,
  parameter logic [15:0] RST_CRC = 16'h0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] COPCRCEN_i,
  input  logic [7:0] COPCRCINIT1_i,
  input  logic [7:0] COPCRCINIT2_i,
  input  logic [7:0] COPCRCI1_i,
  input  logic [7:0] COPCRCI2_i,
  output logic [7:0] COPCRCO1_o,
  output logic [7:0] COPCRCO2_o,
  output logic [7:0] COPCRCSTAT_o,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        en0_q;
  logic        armed_q;
  logic        start_edge;
  logic [15:0] crc_q, crc_d;
  logic [15:0] data_q, data_d;
  logic [4:0]  count_q, count_d;
  logic        overrun_q, overrun_d;
  logic        fb;
  logic        busy;
  logic        done;
  logic        unused_en;

  assign unused_en = ^COPCRCEN_i[7:3];

  // armed_q masks the first cycle after reset release, so a START level that
  // was already high across reset is not mistaken for a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en0_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      en0_q   <= COPCRCEN_i[0];
      armed_q <= 1'b1;
    end
  end

  assign start_edge = armed_q & COPCRCEN_i[0] & ~en0_q;
  assign fb         = crc_q[15] ^ data_q[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      crc_q     <= RST_CRC;
      data_q    <= 16'h0000;
      count_q   <= 5'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      data_q    <= data_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    data_d    = data_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_edge) begin
          state_d   = LOAD;
          overrun_d = 1'b0;
        end
      end
      LOAD: begin
        // INIT and BYTE are only looked at here; without INIT the previous
        // result is the starting value, which lets software chain bytes.
        data_d  = COPCRCEN_i[2] ? {COPCRCI1_i, 8'h00} : {COPCRCI2_i, COPCRCI1_i};
        count_d = COPCRCEN_i[2] ? 5'd8 : 5'd16;
        if (COPCRCEN_i[1]) begin
          crc_d = {COPCRCINIT2_i, COPCRCINIT1_i};
        end
        if (start_edge) begin
          overrun_d = 1'b1;
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        crc_d   = {crc_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
        data_d  = {data_q[14:0], 1'b0};
        count_d = count_q - 5'd1;
        if (start_edge) begin
          overrun_d = 1'b1;
        end
        if (count_q == 5'd1) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == LOAD) || (state_q == SHIFT);
  assign done = (state_q == DONE);

  assign COPCRCO1_o   = crc_q[7:0];
  assign COPCRCO2_o   = crc_q[15:8];
  assign COPCRCSTAT_o = {5'b00000, overrun_q, done, busy};
  assign dbg_state    = state_q;

endmodule
